// File: rtl/ega_blit_pkg.sv
// Shared definitions for the EGA blit master: state encoding, VGA/EGA port
// numbers, register indices and the A0000 memory segment prefix.
package ega_blit_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETUP,
      ST_MEM_SET,
      ST_MEM_RD,
      ST_MEM_WAIT,
      ST_MEM_WR,
      ST_MEM_HOLD,
      ST_RESTORE,
      ST_DONE
   } blitState_t;

   localparam logic [11:0] PORT_SEQ_IDX  = 12'h3C4;
   localparam logic [11:0] PORT_SEQ_DATA = 12'h3C5;
   localparam logic [11:0] PORT_GC_IDX   = 12'h3CE;
   localparam logic [11:0] PORT_GC_DATA  = 12'h3CF;

   localparam logic [7:0] SEQ_MAP_MASK  = 8'h02;
   localparam logic [7:0] GC_SET_RESET  = 8'h00;
   localparam logic [7:0] GC_ENABLE_SR  = 8'h01;
   localparam logic [7:0] GC_MODE       = 8'h05;
   localparam logic [7:0] GC_BIT_MASK   = 8'h08;

   localparam logic [5:0] MEM_PREFIX = 6'b101000;

   function automatic logic [19:0] memAddr(input logic [13:0] off);
      return {MEM_PREFIX, off};
   endfunction

   function automatic logic [19:0] ioAddr(input logic [11:0] port);
      return {8'h00, port};
   endfunction

endpackage

// File: rtl/ega_blit_regseq.sv
// Register programming table: steps 0..9 set up the sequencer/graphics
// controller for the command, steps 10..15 put them back to their defaults.
module ega_blit_regseq
   import ega_blit_pkg::*;
(
   input  logic [3:0]  step,
   input  logic        copy,
   input  logic [3:0]  color,
   input  logic [3:0]  planes,
   output logic [11:0] port,
   output logic [7:0]  data,
   output logic        lastSetup,
   output logic        lastRestore
);

   always_comb begin
      port = PORT_SEQ_IDX;
      data = SEQ_MAP_MASK;
      case (step)
         4'd0:  begin port = PORT_SEQ_IDX;  data = SEQ_MAP_MASK;            end
         4'd1:  begin port = PORT_SEQ_DATA; data = {4'h0, planes};          end
         4'd2:  begin port = PORT_GC_IDX;   data = GC_SET_RESET;            end
         4'd3:  begin port = PORT_GC_DATA;  data = {4'h0, color};           end
         4'd4:  begin port = PORT_GC_IDX;   data = GC_ENABLE_SR;            end
         4'd5:  begin port = PORT_GC_DATA;  data = copy ? 8'h00 : 8'h0F;    end
         4'd6:  begin port = PORT_GC_IDX;   data = GC_MODE;                 end
         // Copy uses write mode 1 so the latches loaded by the read are stored.
         4'd7:  begin port = PORT_GC_DATA;  data = copy ? 8'h01 : 8'h00;    end
         4'd8:  begin port = PORT_GC_IDX;   data = GC_BIT_MASK;             end
         4'd9:  begin port = PORT_GC_DATA;  data = 8'hFF;                   end
         4'd10: begin port = PORT_GC_IDX;   data = GC_ENABLE_SR;            end
         4'd11: begin port = PORT_GC_DATA;  data = 8'h00;                   end
         4'd12: begin port = PORT_GC_IDX;   data = GC_MODE;                 end
         4'd13: begin port = PORT_GC_DATA;  data = 8'h00;                   end
         4'd14: begin port = PORT_SEQ_IDX;  data = SEQ_MAP_MASK;            end
         default: begin port = PORT_SEQ_DATA; data = 8'h0F;                 end
      endcase
      lastSetup   = (step == 4'd9);
      lastRestore = (step == 4'd15);
   end

endmodule

// File: rtl/ega_blit_master.sv
// EGA blit master: programs the card registers, runs a solid fill or a latched
// copy over display memory, then restores the registers and pulses oDone.
module ega_blit_master
   import ega_blit_pkg::*;
#(
   parameter int TIMEOUT = 8
)(
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iStart,
   input  logic        iCopy,
   input  logic [13:0] iDst,
   input  logic [13:0] iSrc,
   input  logic [13:0] iCount,
   input  logic [3:0]  iColor,
   input  logic [3:0]  iPlanes,
   output logic        oBusy,
   output logic        oDone,
   output logic        oErr,
   output logic [19:0] oAddr,
   output logic [7:0]  oWrData,
   output logic        oWrMem,
   output logic        oRdMem,
   output logic        oWrIo,
   input  logic [7:0]  iRdData,
   input  logic        iSel,
   output blitState_t  oState
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   blitState_t  state, stateNext;
   logic [3:0]  step, stepNext;
   logic        phase, phaseNext;
   logic [13:0] dst, dstNext, src, srcNext, remain, remainNext;
   logic        copyR, copyNext, errR, errNext;
   logic [3:0]  colorR, colorNext, planesR, planesNext;
   logic [7:0]  waitCnt, waitNext;
   logic [1:0]  holdCnt, holdNext;

   logic [11:0] seqPort;
   logic [7:0]  seqData;
   logic        seqLastSetup, seqLastRestore;

   // Read data goes to the card's latches; this block never looks at it.
   logic unusedRdData;
   assign unusedRdData = ^iRdData;

   ega_blit_regseq uRegSeq (
      .step        (step),
      .copy        (copyR),
      .color       (colorR),
      .planes      (planesR),
      .port        (seqPort),
      .data        (seqData),
      .lastSetup   (seqLastSetup),
      .lastRestore (seqLastRestore)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state   <= ST_IDLE;
         step    <= '0;
         phase   <= 1'b0;
         dst     <= '0;
         src     <= '0;
         remain  <= '0;
         copyR   <= 1'b0;
         errR    <= 1'b0;
         colorR  <= '0;
         planesR <= '0;
         waitCnt <= '0;
         holdCnt <= '0;
      end else begin
         state   <= stateNext;
         step    <= stepNext;
         phase   <= phaseNext;
         dst     <= dstNext;
         src     <= srcNext;
         remain  <= remainNext;
         copyR   <= copyNext;
         errR    <= errNext;
         colorR  <= colorNext;
         planesR <= planesNext;
         waitCnt <= waitNext;
         holdCnt <= holdNext;
      end
   end

   always_comb begin
      stateNext  = state;
      stepNext   = step;
      phaseNext  = phase;
      dstNext    = dst;
      srcNext    = src;
      remainNext = remain;
      copyNext   = copyR;
      errNext    = errR;
      colorNext  = colorR;
      planesNext = planesR;
      waitNext   = waitCnt;
      holdNext   = holdCnt;
      oWrIo      = 1'b0;
      oWrMem     = 1'b0;
      oRdMem     = 1'b0;
      oAddr      = '0;
      oWrData    = '0;
      oDone      = 1'b0;
      oErr       = 1'b0;
      oBusy      = (state != ST_IDLE);

      case (state)
         ST_IDLE: begin
            if (iStart) begin
               copyNext   = iCopy;
               dstNext    = iDst;
               srcNext    = iSrc;
               remainNext = iCount;
               colorNext  = iColor;
               planesNext = iPlanes;
               stepNext   = '0;
               phaseNext  = 1'b0;
               errNext    = 1'b0;
               stateNext  = ST_SETUP;
            end
         end
         ST_SETUP, ST_RESTORE: begin
            // Each IO write is a strobe cycle followed by one quiet cycle.
            oAddr     = ioAddr(seqPort);
            oWrData   = seqData;
            oWrIo     = ~phase;
            phaseNext = ~phase;
            if (phase) begin
               stepNext = step + 4'd1;
               if (state == ST_SETUP && seqLastSetup) begin
                  if (remain == '0)
                     stateNext = ST_RESTORE;
                  else
                     stateNext = copyR ? ST_MEM_SET : ST_MEM_WR;
               end else if (state == ST_RESTORE && seqLastRestore) begin
                  stateNext = ST_DONE;
               end
            end
         end
         ST_MEM_SET: begin
            oAddr     = memAddr(src);
            stateNext = ST_MEM_RD;
         end
         ST_MEM_RD: begin
            oAddr     = memAddr(src);
            oRdMem    = 1'b1;
            waitNext  = '0;
            stateNext = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            oAddr = memAddr(src);
            if (iSel) begin
               stateNext = ST_MEM_WR;
            end else if (waitCnt == WAIT_LAST) begin
               errNext   = 1'b1;
               stateNext = ST_RESTORE;
            end else begin
               waitNext = waitCnt + 8'd1;
            end
         end
         ST_MEM_WR: begin
            oAddr     = memAddr(dst);
            oWrData   = 8'hFF;
            oWrMem    = 1'b1;
            holdNext  = '0;
            stateNext = ST_MEM_HOLD;
         end
         ST_MEM_HOLD: begin
            // Address stays put while the responder's write pipeline drains.
            oAddr   = memAddr(dst);
            oWrData = 8'hFF;
            if (holdCnt == 2'd2) begin
               dstNext    = dst + 14'd1;
               srcNext    = src + 14'd1;
               remainNext = remain - 14'd1;
               if (remain == 14'd1)
                  stateNext = ST_RESTORE;
               else
                  stateNext = copyR ? ST_MEM_SET : ST_MEM_WR;
            end else begin
               holdNext = holdCnt + 2'd1;
            end
         end
         ST_DONE: begin
            oDone     = 1'b1;
            oErr      = errR;
            stateNext = ST_IDLE;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   assign oState = state;

endmodule

// File: tb/tb_ega_blit_master.sv
// Bench for ega_blit_master: builds a cycle-by-cycle expected bus trace for
// each command and checks the DUT against it, with a delayed iSel responder.
module tb_ega_blit_master;
   import ega_blit_pkg::*;

   localparam int TMO  = 8;
   localparam int MAXC = 256;

   logic        iClk = 1'b0;
   logic        iRst, iStart, iCopy;
   logic [13:0] iDst, iSrc, iCount;
   logic [3:0]  iColor, iPlanes;
   logic        oBusy, oDone, oErr;
   logic [19:0] oAddr;
   logic [7:0]  oWrData;
   logic        oWrMem, oRdMem, oWrIo;
   logic [7:0]  iRdData;
   logic        iSel;
   blitState_t  oState;

   int errors = 0;
   int checks = 0;
   int selPend, ioSeen, memSeen;

   // expected trace, indexed by cycle after acceptance (cycle 1 = first busy)
   logic [2:0]  expStb [MAXC];   // {wrIo, rdMem, wrMem}
   logic [19:0] expAddr[MAXC];
   bit          addrCare[MAXC];
   logic [7:0]  expData[MAXC];
   int          lastCyc;
   bit          expErr;

   always #5 iClk = ~iClk;

   ega_blit_master #(.TIMEOUT(TMO)) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iCopy(iCopy),
      .iDst(iDst), .iSrc(iSrc), .iCount(iCount), .iColor(iColor),
      .iPlanes(iPlanes), .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
      .oAddr(oAddr), .oWrData(oWrData), .oWrMem(oWrMem), .oRdMem(oRdMem),
      .oWrIo(oWrIo), .iRdData(iRdData), .iSel(iSel), .oState(oState)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic putIo(inout int c, input logic [11:0] port, input logic [7:0] data);
      expStb[c]   = 3'b100;
      expAddr[c]  = {8'h00, port};
      addrCare[c] = 1'b1;
      expData[c]  = data;
      c += 2;
   endtask

   // d = cycles from oRdMem to iSel; 0 means the responder never answers
   task automatic buildModel(input bit cp, input logic [13:0] dst, input logic [13:0] src,
                             input logic [13:0] cnt, input logic [3:0] color,
                             input logic [3:0] planes, input int d);
      int c, waitLen;
      logic [13:0] dd, ss;
      for (int i = 0; i < MAXC; i++) begin
         expStb[i] = '0; expAddr[i] = '0; addrCare[i] = 1'b0; expData[i] = '0;
      end
      expErr = 1'b0;
      c = 1;
      putIo(c, 12'h3C4, 8'h02); putIo(c, 12'h3C5, {4'h0, planes});
      putIo(c, 12'h3CE, 8'h00); putIo(c, 12'h3CF, {4'h0, color});
      putIo(c, 12'h3CE, 8'h01); putIo(c, 12'h3CF, cp ? 8'h00 : 8'h0F);
      putIo(c, 12'h3CE, 8'h05); putIo(c, 12'h3CF, cp ? 8'h01 : 8'h00);
      putIo(c, 12'h3CE, 8'h08); putIo(c, 12'h3CF, 8'hFF);
      dd = dst;
      ss = src;
      for (int b = 0; b < int'(cnt) && !expErr; b++) begin
         if (cp) begin
            waitLen = (d == 0) ? TMO : d;
            expAddr[c] = {6'b101000, ss}; addrCare[c] = 1'b1; c++;
            expStb[c] = 3'b010; expAddr[c] = {6'b101000, ss}; addrCare[c] = 1'b1; c++;
            for (int w = 0; w < waitLen; w++) begin
               expAddr[c] = {6'b101000, ss}; addrCare[c] = 1'b1; c++;
            end
            if (d == 0) expErr = 1'b1;
         end
         if (!expErr) begin
            expStb[c]  = 3'b001;
            expData[c] = 8'hFF;
            for (int h = 0; h < 4; h++) begin
               expAddr[c] = {6'b101000, dd}; addrCare[c] = 1'b1; c++;
            end
            dd = dd + 14'd1;
            ss = ss + 14'd1;
         end
      end
      putIo(c, 12'h3CE, 8'h01); putIo(c, 12'h3CF, 8'h00);
      putIo(c, 12'h3CE, 8'h05); putIo(c, 12'h3CF, 8'h00);
      putIo(c, 12'h3C4, 8'h02); putIo(c, 12'h3C5, 8'h0F);
      lastCyc = c;
   endtask

   task automatic checkIdleOutputs(input string tag);
      chk({tag, " ctrl"}, {oBusy, oDone, oErr, oWrIo, oRdMem, oWrMem}, 6'b0);
      chk({tag, " addr"}, oAddr, 20'h0);
      chk({tag, " data"}, oWrData, 8'h0);
      chk({tag, " state"}, oState, ST_IDLE);
   endtask

   task automatic runCmd(input bit cp, input logic [13:0] dst, input logic [13:0] src,
                         input logic [13:0] cnt, input logic [3:0] color,
                         input logic [3:0] planes, input int d, input int abortAt);
      buildModel(cp, dst, src, cnt, color, planes, d);
      ioSeen  = 0;
      memSeen = 0;
      selPend = 0;
      @(negedge iClk);
      iStart = 1'b1; iCopy = cp; iDst = dst; iSrc = src; iCount = cnt;
      iColor = color; iPlanes = planes; iSel = 1'b0;
      for (int k = 1; k <= lastCyc + 1; k++) begin
         @(negedge iClk);
         chk($sformatf("c%0d busy", k), oBusy, 32'(k <= lastCyc));
         chk($sformatf("c%0d strobes", k), {oWrIo, oRdMem, oWrMem}, expStb[k]);
         if (addrCare[k]) chk($sformatf("c%0d addr", k), oAddr, expAddr[k]);
         if (expStb[k] != 3'b0) chk($sformatf("c%0d wrdata", k), oWrData, expData[k]);
         chk($sformatf("c%0d done", k), oDone, 32'(k == lastCyc));
         if (k == lastCyc) chk("done err", oErr, expErr);
         if (oWrIo) ioSeen++;
         if (oWrMem || oRdMem) memSeen++;
         // responder: pulses iSel d cycles after it sees oRdMem
         iSel = 1'b0;
         if (selPend > 0) begin
            selPend--;
            if (selPend == 0) iSel = 1'b1;
         end
         if (oRdMem && d > 0) selPend = d;
         iRdData = 8'($urandom);
         // random command noise while busy must be ignored
         iStart = (k <= lastCyc) ? 1'($urandom_range(0, 1)) : 1'b0;
         iCopy  = 1'($urandom);
         iDst   = 14'($urandom);
         iSrc   = 14'($urandom);
         iCount = 14'($urandom);
         if (k == abortAt) begin
            chk("abort state", oState, ST_MEM_HOLD);
            iStart = 1'b0;
            iRst   = 1'b1;
            @(negedge iClk);
            checkIdleOutputs("abort");
            iRst = 1'b0;
            for (int j = 0; j < 6; j++) begin
               @(negedge iClk);
               chk($sformatf("post-abort %0d", j),
                   {oBusy, oDone, oWrIo, oRdMem, oWrMem}, 5'b0);
            end
            return;
         end
      end
      iStart = 1'b0;
      iSel   = 1'b0;
   endtask

   initial begin
      logic [13:0] rDst, rSrc, rCnt;
      int rD;
      bit rCp;
      iRst = 1'b1; iStart = 1'b0; iCopy = 1'b0; iDst = '0; iSrc = '0; iCount = '0;
      iColor = '0; iPlanes = '0; iRdData = '0; iSel = 1'b0;
      repeat (3) @(negedge iClk);
      checkIdleOutputs("reset");
      iRst = 1'b0;
      @(negedge iClk);
      checkIdleOutputs("after reset");

      runCmd(1'b0, 14'h0010, 14'h0000, 14'd2, 4'h5, 4'hF, 1, 0);   // basic fill
      runCmd(1'b1, 14'h0200, 14'h0100, 14'd1, 4'h3, 4'hA, 1, 0);   // basic copy
      runCmd(1'b0, 14'h3FFF, 14'h0000, 14'd2, 4'h9, 4'h3, 1, 0);   // dst wrap
      runCmd(1'b1, 14'h3FFE, 14'h3FFF, 14'd3, 4'h0, 4'hF, 2, 0);   // src/dst wrap
      runCmd(1'b1, 14'h0040, 14'h0080, 14'd3, 4'h1, 4'h7, 0, 0);   // timeout
      runCmd(1'b1, 14'h0040, 14'h0080, 14'd2, 4'h1, 4'h7, TMO, 0); // last-chance iSel
      runCmd(1'b0, 14'h1234, 14'h0000, 14'd0, 4'hC, 4'h5, 1, 0);
      chk("cnt0 fill io", ioSeen, 16);
      chk("cnt0 fill mem", memSeen, 0);
      runCmd(1'b1, 14'h1234, 14'h0321, 14'd0, 4'hC, 4'h5, 1, 0);
      chk("cnt0 copy io", ioSeen, 16);
      chk("cnt0 copy mem", memSeen, 0);
      runCmd(1'b0, 14'h0100, 14'h0000, 14'd3, 4'h2, 4'hF, 1, 22);  // reset in MEM_HOLD
      runCmd(1'b0, 14'h0300, 14'h0000, 14'd1, 4'h6, 4'h1, 1, 0);   // recovers after abort

      for (int t = 0; t < 12; t++) begin
         rCp  = 1'($urandom);
         rDst = ($urandom_range(0, 3) == 0) ? 14'h3FFE : 14'($urandom);
         rSrc = ($urandom_range(0, 3) == 0) ? 14'h3FFD : 14'($urandom);
         rCnt = 14'($urandom_range(0, 5));
         rD   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMO));
         runCmd(rCp, rDst, rSrc, rCnt, 4'($urandom), 4'($urandom), rD, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
